// File: rtl/approx_sweep_checker_pkg.sv
// Shared definitions for the approximate-circuit sweep checker.
//   state_t        : checker FSM encoding
//   DEF_*          : default circuit-under-test geometry and error threshold
//   sum_w / cnt_w  : width helpers for the error sum and violation counter
package approx_chk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_N_IN  = 4;
    localparam int DEF_N_OUT = 3;
    localparam int DEF_ET    = 3;

    // 2^n_in errors of at most 2^n_out-1 each always fit in n_out+n_in bits.
    function automatic int sum_w(input int n_in, input int n_out);
        return n_out + n_in;
    endfunction

    // Must hold the value 2^n_in when every vector violates.
    function automatic int cnt_w(input int n_in);
        return n_in + 1;
    endfunction

    localparam int SUM_W = sum_w(DEF_N_IN, DEF_N_OUT);
    localparam int CNT_W = cnt_w(DEF_N_IN);

endpackage

// File: rtl/approx_sweep_checker_if.sv
// Bus between the sweep checker and the pair of combinational circuits it tests.
//   cut_in     : vector applied to both the exact and the approximate circuit
//   exact_out  : exact circuit response to cut_in
//   approx_out : approximate circuit response to cut_in
// master = checker side, slave = circuit-under-test side.
interface approx_sweep_checker_if
    import approx_chk_pkg::*;
#(
    parameter int N_IN  = DEF_N_IN,
    parameter int N_OUT = DEF_N_OUT
);
    logic [N_IN-1:0]  cut_in;
    logic [N_OUT-1:0] exact_out;
    logic [N_OUT-1:0] approx_out;

    modport master (output cut_in, input exact_out, input approx_out);
    modport slave  (input cut_in, output exact_out, output approx_out);
endinterface

// File: rtl/approx_err_accum.sv
// Capture stage plus error statistics for the sweep checker.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset
//   clear             : wipe statistics and capture stage (new sweep accepted)
//   cap_en            : capture vec/exact/approx this edge
//   vec, exact, approx: current vector and the two circuit responses
//   max_err, err_sum, viol_cnt, first_fail_vec, first_fail_valid : results
module approx_err_accum
    import approx_chk_pkg::*;
#(
    parameter int N_IN  = DEF_N_IN,
    parameter int N_OUT = DEF_N_OUT,
    parameter int ET    = DEF_ET
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic                           cap_en,
    input  logic [N_IN-1:0]                vec,
    input  logic [N_OUT-1:0]               exact,
    input  logic [N_OUT-1:0]               approx,
    output logic [N_OUT-1:0]               max_err,
    output logic [sum_w(N_IN, N_OUT)-1:0]  err_sum,
    output logic [cnt_w(N_IN)-1:0]         viol_cnt,
    output logic [N_IN-1:0]                first_fail_vec,
    output logic                           first_fail_valid
);
    localparam int S_W = sum_w(N_IN, N_OUT);
    localparam int C_W = cnt_w(N_IN);
    localparam logic [N_OUT-1:0] ET_V = N_OUT'(ET);

    logic             s_vld;
    logic [N_IN-1:0]  s_vec;
    logic [N_OUT-1:0] s_exact;
    logic [N_OUT-1:0] s_approx;
    logic [N_OUT-1:0] err;
    logic             viol;

    // Larger minus smaller keeps the difference unsigned without a sign bit.
    always_comb begin
        err = '0;
        if (s_exact >= s_approx) err = s_exact - s_approx;
        else                     err = s_approx - s_exact;
    end

    assign viol = (err > ET_V);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_vld            <= 1'b0;
            s_vec            <= '0;
            s_exact          <= '0;
            s_approx         <= '0;
            max_err          <= '0;
            err_sum          <= '0;
            viol_cnt         <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else if (clear) begin
            s_vld            <= 1'b0;
            s_vec            <= '0;
            s_exact          <= '0;
            s_approx         <= '0;
            max_err          <= '0;
            err_sum          <= '0;
            viol_cnt         <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            s_vld <= cap_en;
            if (cap_en) begin
                s_vec    <= vec;
                s_exact  <= exact;
                s_approx <= approx;
            end
            if (s_vld) begin
                if (err > max_err) max_err <= err;
                err_sum <= err_sum + S_W'(err);
                if (viol) begin
                    viol_cnt <= viol_cnt + C_W'(1);
                    if (!first_fail_valid) begin
                        first_fail_vec   <= s_vec;
                        first_fail_valid <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/approx_sweep_checker.sv
// Exhaustive-sweep checker for an approximate circuit against its exact twin.
// Drives every vector 0..2^N_IN-1 onto the shared cut bus, compares the two
// responses one edge later and reports worst/total error against ET.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   start        : one-cycle sweep request (honoured in IDLE and DONE only)
//   cut          : master side of the circuit-under-test bus
//   busy, done   : sweep/drain in progress, results valid
//   pass         : max_err <= ET, qualified by done
//   max_err, err_sum, viol_cnt, first_fail_vec, first_fail_valid : statistics
//
// state | meaning
// IDLE  | waiting for start, outputs at reset values
// SWEEP | driving vectors, capturing responses each edge
// DRAIN | last vector captured, accumulating it
// DONE  | results valid and held until start or reset
module approx_sweep_checker
    import approx_chk_pkg::*;
#(
    parameter int N_IN  = DEF_N_IN,
    parameter int N_OUT = DEF_N_OUT,
    parameter int ET    = DEF_ET
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    approx_sweep_checker_if.master         cut,
    output logic                           busy,
    output logic                           done,
    output logic                           pass,
    output logic [N_OUT-1:0]               max_err,
    output logic [sum_w(N_IN, N_OUT)-1:0]  err_sum,
    output logic [cnt_w(N_IN)-1:0]         viol_cnt,
    output logic [N_IN-1:0]                first_fail_vec,
    output logic                           first_fail_valid
);
    localparam logic [N_IN-1:0]  LAST_VEC = '1;
    localparam logic [N_OUT-1:0] ET_V     = N_OUT'(ET);

    state_t          state_q, state_d;
    logic [N_IN-1:0] cut_in_q, cut_in_d;
    logic            accept;
    logic            cap_en;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cut_in_q <= '0;
        end else begin
            state_q  <= state_d;
            cut_in_q <= cut_in_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cut_in_d = cut_in_q;
        accept   = 1'b0;
        cap_en   = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                done = (state_q == DONE);
                if (start) begin
                    accept   = 1'b1;
                    cut_in_d = '0;
                    state_d  = SWEEP;
                end
            end
            SWEEP: begin
                busy   = 1'b1;
                cap_en = 1'b1;
                // Hold on the final vector rather than wrapping to 0.
                if (cut_in_q == LAST_VEC) state_d = DRAIN;
                else                      cut_in_d = cut_in_q + N_IN'(1);
            end
            DRAIN: begin
                busy    = 1'b1;
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cut.cut_in = cut_in_q;
    assign pass       = done && (max_err <= ET_V);

    approx_err_accum #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT),
        .ET    (ET)
    ) u_accum (
        .clk              (clk),
        .rst_n            (rst_n),
        .clear            (accept),
        .cap_en           (cap_en),
        .vec              (cut_in_q),
        .exact            (cut.exact_out),
        .approx           (cut.approx_out),
        .max_err          (max_err),
        .err_sum          (err_sum),
        .viol_cnt         (viol_cnt),
        .first_fail_vec   (first_fail_vec),
        .first_fail_valid (first_fail_valid)
    );

endmodule
